// File: rtl/priority_decoder_dispatch_pkg.sv
// Shared types and helpers for the decode-and-dispatch block.
// Helpers work on 32-bit vectors so any IDX_W up to 5 can reuse them.
package priority_decoder_dispatch_pkg;

    localparam int IDX_W_DEF = 2;

    typedef enum logic {IDLE, OFFER} state_t;

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'(1) << idx;
    endfunction

    function automatic logic [4:0] oh2idx(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = r | 5'(i);
        return r;
    endfunction

    // mask = N-1; search starts just after last and wraps modulo N
    function automatic logic [31:0] rr_pick(input logic [31:0] vec,
                                            input logic [4:0]  last,
                                            input logic [4:0]  mask);
        logic [31:0] g;
        logic [4:0]  k;
        logic        found;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i <= int'(mask) + 1) begin
                k = (last + 5'(i)) & mask;
                if (vec[k] && !found) begin
                    g[k]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/priority_decoder_dispatch_rr_pick_n.sv
// Combinational round-robin selector: one-hot grant of the first set bit after last.
module rr_pick_n
    import priority_decoder_dispatch_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    localparam int N    = 1 << IDX_W
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic             any
);

    logic [31:0] g32;

    always_comb begin
        g32   = rr_pick(32'(vec), 5'(last), 5'(N - 1));
        grant = g32[N-1:0];
        any   = |vec;
    end

endmodule

// File: rtl/priority_decoder_dispatch.sv
// Decodes {v,y} events into a pending vector and dispatches them
// round-robin, one per valid/ready handshake.
module priority_decoder_dispatch
    import priority_decoder_dispatch_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    localparam int N    = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [IDX_W-1:0] in_y,
    output logic [N-1:0]     dec,
    output logic             dec_v,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     sel,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sel_idx;
    logic [31:0]      set32;
    logic [N-1:0]     set_vec, clr_vec, pend_nxt;
    logic [N-1:0]     pick_vec, grant;
    logic [IDX_W-1:0] pick_last;
    logic             hs, any, ovf_hit;

    always_comb begin
        set32    = onehot(5'(in_y));
        set_vec  = in_v ? set32[N-1:0] : '0;
        hs       = sel_valid & sel_ready;
        clr_vec  = hs ? sel : '0;
        // set wins over a same-cycle clear, and that case is a fresh event
        pend_nxt = (pending & ~clr_vec) | set_vec;
        ovf_hit  = |(pending & set_vec & ~clr_vec);
        sel_idx  = IDX_W'(oh2idx(32'(sel)));
        // one selector: IDLE load from pending, OFFER reload excluding the accepted line
        if (state == OFFER) begin
            pick_vec  = pending & ~sel;
            pick_last = sel_idx;
        end else begin
            pick_vec  = pending;
            pick_last = last;
        end
    end

    rr_pick_n #(.IDX_W(IDX_W)) u_pick (
        .vec   (pick_vec),
        .last  (pick_last),
        .grant (grant),
        .any   (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec       <= '0;
            dec_v     <= 1'b0;
            pending   <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            ovf       <= 1'b0;
            last      <= '1;
            state     <= IDLE;
        end else begin
            dec     <= set_vec;
            dec_v   <= in_v;
            pending <= pend_nxt;
            ovf     <= ovf_hit | (ovf & ~ovf_clr);
            case (state)
                IDLE: begin
                    if (any) begin
                        sel       <= grant;
                        sel_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (hs) begin
                        last <= sel_idx;
                        if (any) begin
                            sel <= grant;
                        end else begin
                            sel       <= '0;
                            sel_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_decoder_dispatch.sv
// Scoreboarded bench: expected dispatch order is queued with the stimulus and
// popped by a monitor on every handshake; direct checks cover decode/pending/ovf.
module tb_priority_decoder_dispatch;

    localparam int IDX_W = 2;
    localparam int N     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_v = 1'b0;
    logic [IDX_W-1:0] in_y = '0;
    logic [N-1:0]     dec, pending, sel;
    logic             dec_v, sel_valid, ovf;
    logic             sel_ready = 1'b0;
    logic             ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] exp_q[$];

    priority_decoder_dispatch #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_v      (in_v),
        .in_y      (in_y),
        .dec       (dec),
        .dec_v     (dec_v),
        .pending   (pending),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input int y);
        in_v = 1'b1;
        in_y = IDX_W'(y);
    endtask

    // handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && sel_valid && sel_ready) begin
            if (exp_q.size() == 0) begin
                chk("hs_unexpected", 32'(sel), 32'h0);
            end else begin
                chk("hs_sel", 32'(sel), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_dec", 32'(dec), 0);
        chk("rst_dec_v", 32'(dec_v), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_sel_valid", 32'(sel_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // single event on line 2: decode, latch, then offer
        ev(2);
        step();
        in_v = 1'b0;
        chk("t1_dec", 32'(dec), 32'h4);
        chk("t1_dec_v", 32'(dec_v), 1);
        chk("t1_pending", 32'(pending), 32'h4);
        chk("t1_sv_early", 32'(sel_valid), 0);
        step();
        chk("t1_sel", 32'(sel), 32'h4);
        chk("t1_sel_valid", 32'(sel_valid), 1);
        chk("t1_dec_idle", 32'(dec), 0);
        chk("t1_dec_v_idle", 32'(dec_v), 0);
        exp_q.push_back(4'b0100);
        sel_ready = 1'b1;
        step();
        sel_ready = 1'b0;
        chk("t1_done_sv", 32'(sel_valid), 0);
        chk("t1_done_pend", 32'(pending), 0);

        // lines 0,1,3 back-to-back with ready held high
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        sel_ready = 1'b1;
        ev(0); step();
        ev(1); step();
        ev(3); step();
        in_v = 1'b0;
        step();
        step();
        chk("t2_sv", 32'(sel_valid), 0);
        chk("t2_pend", 32'(pending), 0);
        step();
        sel_ready = 1'b0;

        // stalled offer of line 1 while 0 and 3 arrive; line 1 re-arrives on accept
        ev(1); step();
        ev(0); step();
        ev(3); step();
        chk("t3_sel", 32'(sel), 32'h2);
        chk("t3_pend", 32'(pending), 32'hb);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        sel_ready = 1'b1;
        ev(1); step();
        in_v = 1'b0;
        chk("t3_pend_keep", 32'(pending), 32'hb);
        chk("t3_sel_wrap", 32'(sel), 32'h8);
        step(); step(); step();
        sel_ready = 1'b0;
        chk("t3_sv", 32'(sel_valid), 0);
        chk("t3_pend_end", 32'(pending), 0);
        chk("t3_ovf", 32'(ovf), 0);

        // sel must hold through a 5-cycle stall
        ev(1); step();
        in_v = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) ev(3);
            else in_v = 1'b0;
            step();
            chk("t4_sel_hold", 32'(sel), 32'h2);
            chk("t4_sv_hold", 32'(sel_valid), 1);
        end
        in_v = 1'b0;
        chk("t4_pend", 32'(pending), 32'ha);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        sel_ready = 1'b1;
        step();
        chk("t4_next", 32'(sel), 32'h8);
        step();
        sel_ready = 1'b0;
        chk("t4_sv", 32'(sel_valid), 0);

        // overflow on a pending, unaccepted line; clear interplay
        ev(2); step();
        in_v = 1'b0;
        step();
        chk("t5_pend", 32'(pending), 32'h4);
        ev(2); step();
        in_v = 1'b0;
        chk("t5_ovf", 32'(ovf), 1);
        chk("t5_pend_same", 32'(pending), 32'h4);
        ev(2); ovf_clr = 1'b1; step();
        in_v = 1'b0;
        chk("t5_ovf_clr_vs_new", 32'(ovf), 1);
        step();
        ovf_clr = 1'b0;
        chk("t5_ovf_cleared", 32'(ovf), 0);

        // line 2 accepted as it re-arrives: set wins, no overflow, re-offered
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        sel_ready = 1'b1;
        ev(2); step();
        in_v = 1'b0;
        chk("t6_pend", 32'(pending), 32'h4);
        chk("t6_ovf", 32'(ovf), 0);
        chk("t6_sv_idle", 32'(sel_valid), 0);
        step();
        chk("t6_reoffer_sv", 32'(sel_valid), 1);
        chk("t6_reoffer_sel", 32'(sel), 32'h4);
        step();
        sel_ready = 1'b0;
        chk("t6_pend_end", 32'(pending), 0);

        // async reset mid-offer with an overflow flagged
        ev(1); step();
        ev(3); step();
        ev(3); step();
        in_v = 1'b0;
        chk("t7_pre_sv", 32'(sel_valid), 1);
        chk("t7_pre_ovf", 32'(ovf), 1);
        #2 rst = 1'b1;
        #1;
        chk("t7_sv", 32'(sel_valid), 0);
        chk("t7_sel", 32'(sel), 0);
        chk("t7_pend", 32'(pending), 0);
        chk("t7_ovf", 32'(ovf), 0);
        step();
        rst = 1'b0;
        step();
        chk("t7_stays_idle", 32'(sel_valid), 0);
        chk("q_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
